// File: rtl/frame_seq_umc.sv
// Frame sequencer: turns CPU-phase edges into ticks and issues the
// quarter/half-frame strobes, frame IRQ and $4017 delayed reset.
module frame_seq_umc #(
   parameter int unsigned Q1    = 7456,
   parameter int unsigned Q2    = 14912,
   parameter int unsigned Q3    = 22370,
   parameter int unsigned LAST4 = 29829,
   parameter int unsigned LAST5 = 37281
) (
   input  logic port_CLK,
   input  logic port_RES,
   input  logic port_phi,
   input  logic port_wr4017,
   input  logic port_d7,
   input  logic port_d6,
   input  logic port_rd4015,
   output logic port_aclk,
   output logic port_qframe,
   output logic port_hframe,
   output logic port_irq
);

   localparam logic [15:0] C_Q1 = 16'(Q1);
   localparam logic [15:0] C_Q2 = 16'(Q2);
   localparam logic [15:0] C_Q3 = 16'(Q3);
   localparam logic [15:0] C_L4 = 16'(LAST4);
   localparam logic [15:0] C_L5 = 16'(LAST5);

   logic        phi_d;
   logic        par;
   logic        mode;
   logic        inhibit;
   logic        irq;
   logic [15:0] cnt;
   logic [2:0]  dly;
   logic        aclk_q;
   logic        qframe_q;
   logic        hframe_q;

   logic        tick;
   logic        mode_eff;
   logic        inh_eff;
   logic [15:0] last;
   logic [15:0] cnt_nxt;
   logic [2:0]  dly_nxt;
   logic        dly_fire;
   logic        q_hit;
   logic        h_hit;
   logic        irq_win;
   logic        irq_set;
   logic        irq_clr;

   // A $4017 write takes effect on its own clock, even if a tick lands there.
   always_comb begin
      tick     = port_phi & ~phi_d;
      mode_eff = port_wr4017 ? port_d7 : mode;
      inh_eff  = port_wr4017 ? port_d6 : inhibit;
      last     = mode_eff ? C_L5 : C_L4;
      q_hit    = (cnt == C_Q1) || (cnt == C_Q2) ||
                 (cnt == C_Q3) || (cnt == last - 16'd1);
      h_hit    = (cnt == C_Q2) || (cnt == last - 16'd1);
      irq_win  = (cnt == C_L4 - 16'd2) || (cnt == C_L4 - 16'd1) ||
                 (cnt == C_L4);
      irq_set  = tick & ~mode_eff & ~inh_eff & irq_win;
      irq_clr  = port_rd4015 | (port_wr4017 & port_d6);
      dly_fire = tick & ~port_wr4017 & (dly == 3'd1);
   end

   always_comb begin
      cnt_nxt = cnt;
      if (dly_fire) begin
         cnt_nxt = '0;
      end else if (cnt == last) begin
         cnt_nxt = '0;
      end else begin
         cnt_nxt = cnt + 16'd1;
      end
   end

   // Re-arming from the pre-tick parity lines the reset up with an APU cycle.
   always_comb begin
      dly_nxt = dly;
      if (port_wr4017) begin
         dly_nxt = par ? 3'd3 : 3'd4;
      end else if (tick && dly != 3'd0) begin
         dly_nxt = dly - 3'd1;
      end
   end

   always_ff @(posedge port_CLK) begin
      if (port_RES) begin
         phi_d   <= 1'b0;
         par     <= 1'b0;
         cnt     <= '0;
         dly     <= '0;
         mode    <= 1'b0;
         inhibit <= 1'b0;
      end else begin
         phi_d <= port_phi;
         dly   <= dly_nxt;
         if (tick) begin
            par <= ~par;
            cnt <= cnt_nxt;
         end
         if (port_wr4017) begin
            mode    <= port_d7;
            inhibit <= port_d6;
         end
      end
   end

   // Set beats clear when both land on the same clock.
   always_ff @(posedge port_CLK) begin
      if (port_RES) begin
         irq <= 1'b0;
      end else if (irq_set) begin
         irq <= 1'b1;
      end else if (irq_clr) begin
         irq <= 1'b0;
      end
   end

   always_ff @(posedge port_CLK) begin
      if (port_RES) begin
         aclk_q   <= 1'b0;
         qframe_q <= 1'b0;
         hframe_q <= 1'b0;
      end else begin
         aclk_q   <= tick & par;
         qframe_q <= tick & (q_hit | (dly_fire & mode_eff));
         hframe_q <= tick & (h_hit | (dly_fire & mode_eff));
      end
   end

   assign port_aclk   = aclk_q;
   assign port_qframe = qframe_q;
   assign port_hframe = hframe_q;
   assign port_irq    = irq;

endmodule

// File: tb/tb_frame_seq_umc.sv
// Bench for frame_seq_umc with scaled frame constants; a tick-level
// reference model feeds an expected-value queue compared per sample.
module tb_frame_seq_umc;

   localparam int Q1 = 74;
   localparam int Q2 = 149;
   localparam int Q3 = 223;
   localparam int L4 = 298;
   localparam int L5 = 372;

   logic clk = 1'b0;
   logic res = 1'b1;
   logic phi = 1'b0;
   logic wr  = 1'b0;
   logic d7  = 1'b0;
   logic d6  = 1'b0;
   logic rd  = 1'b0;
   logic aclk, qf, hf, irq;

   int checks = 0;
   int errors = 0;

   logic [3:0] exp_q[$];
   logic [3:0] act_q[$];
   int q_ticks[$];
   int h_ticks[$];
   int n_tick;
   int irq_rise;

   int m_cnt;
   int m_dly;
   bit m_par, m_mode, m_inh, m_irq;

   always #5 clk = ~clk;

   frame_seq_umc #(
      .Q1(Q1), .Q2(Q2), .Q3(Q3), .LAST4(L4), .LAST5(L5)
   ) dut (
      .port_CLK(clk),
      .port_RES(res),
      .port_phi(phi),
      .port_wr4017(wr),
      .port_d7(d7),
      .port_d6(d6),
      .port_rd4015(rd),
      .port_aclk(aclk),
      .port_qframe(qf),
      .port_hframe(hf),
      .port_irq(irq)
   );

   task automatic clear_log();
      n_tick   = 0;
      irq_rise = -1;
      q_ticks.delete();
      h_ticks.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      res = 1'b1;
      repeat (2) @(negedge clk);
      res = 1'b0;
      m_cnt = 0; m_dly = 0;
      m_par = 0; m_mode = 0; m_inh = 0; m_irq = 0;
      clear_log();
   endtask

   task automatic tick(input bit do_rd);
      int c, last;
      bit a, q, h, set;
      @(negedge clk);
      exp_q.push_back({3'b000, m_irq});
      act_q.push_back({aclk, qf, hf, irq});
      phi = 1'b1;
      rd  = do_rd;
      last = m_mode ? L5 : L4;
      c = m_cnt;
      a = m_par;
      q = (c == Q1) || (c == Q2) || (c == Q3) || (c == last - 1);
      h = (c == Q2) || (c == last - 1);
      set = !m_mode && !m_inh && c >= L4 - 2 && c <= L4;
      m_par = !m_par;
      m_cnt = (c == last) ? 0 : c + 1;
      if (m_dly > 0) begin
         m_dly--;
         if (m_dly == 0) begin
            m_cnt = 0;
            if (m_mode) begin q = 1; h = 1; end
         end
      end
      if (set) m_irq = 1;
      else if (do_rd) m_irq = 0;
      exp_q.push_back({a, q, h, m_irq});
      @(negedge clk);
      act_q.push_back({aclk, qf, hf, irq});
      n_tick++;
      if (qf) q_ticks.push_back(n_tick);
      if (hf) h_ticks.push_back(n_tick);
      if (irq && irq_rise < 0) irq_rise = n_tick;
      phi = 1'b0;
      rd  = 1'b0;
   endtask

   task automatic write4017(input bit b7, input bit b6);
      @(negedge clk);
      wr = 1'b1; d7 = b7; d6 = b6;
      m_mode = b7;
      m_inh  = b6;
      m_dly  = m_par ? 3 : 4;
      if (b6) m_irq = 0;
      @(negedge clk);
      wr = 1'b0; d7 = 1'b0; d6 = 1'b0;
      exp_q.push_back({3'b000, m_irq});
      act_q.push_back({aclk, qf, hf, irq});
   endtask

   task automatic read4015();
      @(negedge clk);
      rd = 1'b1;
      m_irq = 0;
      @(negedge clk);
      rd = 1'b0;
      exp_q.push_back({3'b000, m_irq});
      act_q.push_back({aclk, qf, hf, irq});
   endtask

   task automatic test_reset();
      res = 1'b1;
      repeat (3) begin
         @(negedge clk); phi = ~phi;
      end
      @(negedge clk);
      phi = 1'b0;
      checks++;
      if (aclk !== 1'b0) begin
         errors++; $display("FAIL reset_aclk: got %b expected 0", aclk);
      end
      checks++;
      if (qf !== 1'b0) begin
         errors++; $display("FAIL reset_qframe: got %b expected 0", qf);
      end
      checks++;
      if (hf !== 1'b0) begin
         errors++; $display("FAIL reset_hframe: got %b expected 0", hf);
      end
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_4step();
      int eq[$];
      int eh[$];
      bit ok;
      logic [3:0] e, a;
      do_reset();
      repeat (L4 + 1) tick(0);
      eq = '{Q1 + 1, Q2 + 1, Q3 + 1, L4};
      eh = '{Q2 + 1, L4};
      ok = (q_ticks.size() == eq.size());
      if (ok) foreach (eq[i]) if (q_ticks[i] != eq[i]) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL 4step_qticks: got %0d strobes first %0d, expected %0d first %0d",
                  q_ticks.size(), q_ticks.size() > 0 ? q_ticks[0] : -1, eq.size(), eq[0]);
      end
      ok = (h_ticks.size() == eh.size());
      if (ok) foreach (eh[i]) if (h_ticks[i] != eh[i]) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL 4step_hticks: got %0d strobes first %0d, expected %0d first %0d",
                  h_ticks.size(), h_ticks.size() > 0 ? h_ticks[0] : -1, eh.size(), eh[0]);
      end
      checks++;
      if (irq_rise != L4 - 1) begin
         errors++; $display("FAIL 4step_irq_rise: got tick %0d expected %0d", irq_rise, L4 - 1);
      end
      clear_log();
      repeat (Q1 + 1) tick(0);
      checks++;
      if (q_ticks.size() != 1 || q_ticks[0] != Q1 + 1) begin
         errors++;
         $display("FAIL 4step_wrap: got %0d strobes first %0d, expected 1 at %0d",
                  q_ticks.size(), q_ticks.size() > 0 ? q_ticks[0] : -1, Q1 + 1);
      end
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL 4step_irq_hold: got %b expected 1", irq);
      end
      read4015();
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL read_clear: got %b expected 0", irq);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++; $display("FAIL sb_4step: got %b expected %b", a, e);
         end
      end
   endtask

   task automatic test_read_collide();
      logic [3:0] e, a;
      do_reset();
      repeat (L4 - 1) tick(0);
      read4015();
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL collide_pre_read: got %b expected 0", irq);
      end
      tick(1);
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL collide_set_wins: got %b expected 1", irq);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++; $display("FAIL sb_collide: got %b expected %b", a, e);
         end
      end
   endtask

   task automatic test_5step();
      int eq[$];
      int eh[$];
      bit ok;
      logic [3:0] e, a;
      do_reset();
      tick(0);
      write4017(1'b1, 1'b0);
      clear_log();
      repeat (3) tick(0);
      checks++;
      if (q_ticks.size() != 1 || q_ticks[0] != 3 || h_ticks.size() != 1 || h_ticks[0] != 3) begin
         errors++;
         $display("FAIL 5step_arm_strobe: got q %0d h %0d strobes, expected one each at tick 3",
                  q_ticks.size(), h_ticks.size());
      end
      clear_log();
      repeat (L5 + 1) tick(0);
      eq = '{Q1 + 1, Q2 + 1, Q3 + 1, L5};
      eh = '{Q2 + 1, L5};
      ok = (q_ticks.size() == eq.size());
      if (ok) foreach (eq[i]) if (q_ticks[i] != eq[i]) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL 5step_qticks: got %0d strobes last %0d, expected %0d last %0d",
                  q_ticks.size(), q_ticks.size() > 0 ? q_ticks[q_ticks.size() - 1] : -1,
                  eq.size(), L5);
      end
      ok = (h_ticks.size() == eh.size());
      if (ok) foreach (eh[i]) if (h_ticks[i] != eh[i]) ok = 0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL 5step_hticks: got %0d strobes, expected %0d", h_ticks.size(), eh.size());
      end
      checks++;
      if (irq_rise != -1) begin
         errors++; $display("FAIL 5step_irq: got rise at tick %0d expected none", irq_rise);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++; $display("FAIL sb_5step: got %b expected %b", a, e);
         end
      end
   endtask

   task automatic test_rearm();
      logic [3:0] e, a;
      do_reset();
      write4017(1'b0, 1'b0);
      repeat (2) tick(0);
      write4017(1'b0, 1'b0);
      clear_log();
      repeat (4 + Q1 + 1) tick(0);
      checks++;
      if (q_ticks.size() != 1 || q_ticks[0] != 4 + Q1 + 1 || h_ticks.size() != 0) begin
         errors++;
         $display("FAIL rearm_qtick: got %0d strobes first %0d, expected 1 at %0d",
                  q_ticks.size(), q_ticks.size() > 0 ? q_ticks[0] : -1, 4 + Q1 + 1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++; $display("FAIL sb_rearm: got %b expected %b", a, e);
         end
      end
   endtask

   task automatic test_inhibit();
      logic [3:0] e, a;
      do_reset();
      repeat (L4) tick(0);
      checks++;
      if (irq !== 1'b1) begin
         errors++; $display("FAIL inhibit_pre: got %b expected 1", irq);
      end
      write4017(1'b0, 1'b1);
      checks++;
      if (irq !== 1'b0) begin
         errors++; $display("FAIL inhibit_clear: got %b expected 0", irq);
      end
      clear_log();
      repeat (2 * (L4 + 1)) tick(0);
      checks++;
      if (irq_rise != -1) begin
         errors++; $display("FAIL inhibit_no_set: got rise at tick %0d expected none", irq_rise);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++; $display("FAIL sb_inhibit: got %b expected %b", a, e);
         end
      end
   endtask

   task automatic test_res_mid();
      logic [3:0] e, a;
      do_reset();
      repeat (140) tick(0);
      write4017(1'b0, 1'b0);
      repeat (2) tick(0);
      res = 1'b1;
      @(negedge clk);
      checks++;
      if ({aclk, qf, hf, irq} !== 4'b0000) begin
         errors++; $display("FAIL resmid_outputs: got %b expected 0000", {aclk, qf, hf, irq});
      end
      res = 1'b0;
      m_cnt = 0; m_dly = 0;
      m_par = 0; m_mode = 0; m_inh = 0; m_irq = 0;
      clear_log();
      repeat (Q1 + 1) tick(0);
      checks++;
      if (q_ticks.size() != 1 || q_ticks[0] != Q1 + 1) begin
         errors++;
         $display("FAIL resmid_first_q: got %0d strobes first %0d, expected 1 at %0d",
                  q_ticks.size(), q_ticks.size() > 0 ? q_ticks[0] : -1, Q1 + 1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); a = act_q.pop_front();
         checks++;
         if (a !== e) begin
            errors++; $display("FAIL sb_resmid: got %b expected %b", a, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_4step();
      test_read_collide();
      test_5step();
      test_rearm();
      test_inhibit();
      test_res_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
